keypad_matrix_scanner: RTL and testbench

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

---
 rtl/keypad_pkg.sv | 15 +
 rtl/key_event_fifo.sv | 50 +++++
 rtl/keypad_matrix_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: key-code width and event word layout.
// Event word is {press, code}: press in the MSB, key code in the low CODE_W bits.
package keypad_pkg;

  function automatic int calc_code_w(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  function automatic int evt_width(input int code_w);
    return code_w + 1;
  endfunction

  localparam int DB_W = 4;

endpackage

// File: rtl/key_event_fifo.sv
// Generic FIFO: push/pop with full/empty, head visible combinationally, zero-latency read.
// Push while full is ignored unless a pop happens in the same cycle; the caller owns drop policy.
module key_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad scanner: one-hot rows, 2-flop column sync, per-key debounce, press/release events; event valid 1 clock after flip.
// Stalled consumer holds the head stable; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int SCAN_DIV   = 16,
  parameter  int DEBOUNCE   = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int CODE_W     = calc_code_w(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              aclr,
  output logic [ROWS-1:0]   row_out,
  input  logic [COLS-1:0]   col_in,
  output logic [CODE_W-1:0] key,
  output logic              is_pressed,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press,
  input  logic              evt_ready,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int NKEYS = ROWS * COLS;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int EW    = evt_width(CODE_W);

  logic [DW-1:0]   cnt;
  logic [RW-1:0]   row_idx;
  logic            wrap;
  logic [COLS-1:0] sync1;
  logic [COLS-1:0] sync2;
  logic [COLS-1:0] col_lat;

  logic [NKEYS-1:0] stable;
  logic [DB_W-1:0]  db [NKEYS];

  logic [DW-1:0]   col_idx;
  logic            eval_en;
  int              eval_idx;
  logic            sample;
  logic            cur_stable;
  logic [DB_W-1:0] cur_cnt;
  logic            flip;

  logic [CODE_W-1:0] lowest;
  logic [EW-1:0]     push_dat;
  logic [EW-1:0]     head_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  assign wrap = (cnt == DW'(SCAN_DIV - 1));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      cnt     <= '0;
      row_idx <= '0;
      row_out <= ROWS'(1);
    end else begin
      if (wrap) begin
        cnt     <= '0;
        row_out <= (row_out << 1) | (row_out >> (ROWS - 1));
        row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The sync pipe settles on the new row during dwell counts 0..2, so the snapshot at count 3 is clean.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      sync1   <= '0;
      sync2   <= '0;
      col_lat <= '0;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
      if (cnt == DW'(3)) begin
        col_lat <= sync2;
      end
    end
  end

  assign col_idx  = cnt - DW'(4);
  assign eval_en  = (cnt >= DW'(4)) && (cnt < DW'(4 + COLS));
  assign eval_idx = int'(row_idx) * COLS + int'(col_idx);

  always_comb begin
    sample = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (int'(col_idx) == c) begin
        sample = col_lat[c];
      end
    end
  end

  always_comb begin
    cur_stable = 1'b0;
    cur_cnt    = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (eval_idx == i) begin
        cur_stable = stable[i];
        cur_cnt    = db[i];
      end
    end
  end

  assign flip = eval_en && (sample != cur_stable) && (cur_cnt == DB_W'(DEBOUNCE - 1));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      stable <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        db[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (eval_en && (eval_idx == i)) begin
          if (sample == stable[i]) begin
            db[i] <= '0;
          end else if (db[i] == DB_W'(DEBOUNCE - 1)) begin
            stable[i] <= ~stable[i];
            db[i]     <= '0;
          end else begin
            db[i] <= db[i] + 1'b1;
          end
        end
      end
    end
  end

  // Scanning downwards leaves the lowest pressed code as the final assignment.
  always_comb begin
    lowest = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (stable[i]) begin
        lowest = CODE_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      key        <= '0;
      is_pressed <= 1'b0;
    end else begin
      key        <= lowest;
      is_pressed <= |stable;
    end
  end

  assign push_dat = {~cur_stable, CODE_W'(eval_idx)};
  assign pop      = evt_valid && evt_ready;
  assign drop     = flip && fifo_full && !pop;

  key_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .aclr  (aclr),
    .push  (flip),
    .din   (push_dat),
    .pop   (pop),
    .dout  (head_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid             = !fifo_empty;
  assign {evt_press, evt_code} = head_dat;

  // A drop in the same cycle as a clear wins, so no lost event goes unreported.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= (overflow && !ovf_clr) || drop;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench: a per-scan keypad model predicts events and key state; a monitor checks popped events.
module tb_keypad_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NK    = ROWS * COLS;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int SCAN  = 64;

  logic            clock = 1'b0;
  logic            aclr  = 1'b1;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_in;
  logic [3:0]      key;
  logic            is_pressed;
  logic            evt_valid;
  logic [3:0]      evt_code;
  logic            evt_press;
  logic            evt_ready;
  logic            overflow;
  logic            ovf_clr;

  logic [NK-1:0] phys;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int code;
    bit press;
  } exp_t;

  exp_t exp_q[$];
  bit   m_stable[NK];
  int   m_cnt[NK];
  bit   hold;
  int   model_occ;
  bit   exp_ovf;
  int   rdy_mode;
  int   cyc = 0;
  int   first_valid = -1;
  bit   stalled;
  int   held_code;
  int   held_press;
  exp_t e;

  keypad_matrix_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_DIV   (16),
    .DEBOUNCE   (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .aclr       (aclr),
    .row_out    (row_out),
    .col_in     (col_in),
    .key        (key),
    .is_pressed (is_pressed),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_press  (evt_press),
    .evt_ready  (evt_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clock = ~clock;

  // Physical matrix: a closed switch connects its driven row to its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row_out[r] && phys[r*COLS+c]) col_in[c] = 1'b1;
      end
    end
  end

  always @(posedge clock) begin
    if (aclr) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  function automatic int model_key();
    for (int i = 0; i < NK; i++) if (m_stable[i]) return i;
    return 0;
  endfunction

  function automatic int model_any();
    for (int i = 0; i < NK; i++) if (m_stable[i]) return 1;
    return 0;
  endfunction

  task automatic expect_event(input int code, input bit press);
    exp_t n;
    n.code  = code;
    n.press = press;
    if (hold) begin
      if (model_occ < DEPTH) begin
        exp_q.push_back(n);
        model_occ++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_q.push_back(n);
    end
  endtask

  // One scan samples every key once, in code order.
  task automatic model_scan();
    for (int i = 0; i < NK; i++) begin
      if (phys[i] == m_stable[i]) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_stable[i] = !m_stable[i];
          m_cnt[i]    = 0;
          expect_event(i, m_stable[i]);
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_stable[i] = 1'b0;
      m_cnt[i]    = 0;
    end
  endtask

  task automatic run_scan(input bit pulse_clr = 1'b0);
    chk("row_at_scan_start", int'(row_out), 1);
    chk("key", int'(key), model_key());
    chk("is_pressed", int'(is_pressed), model_any());
    model_scan();
    if (pulse_clr) begin
      ovf_clr = 1'b1;
      @(posedge clock);
      #1;
      ovf_clr = 1'b0;
      chk("overflow_after_clr", int'(overflow), 0);
      repeat (SCAN - 1) @(posedge clock);
      #1;
    end else begin
      repeat (SCAN) @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    if (aclr) begin
      stalled     = 1'b0;
      first_valid = -1;
    end else begin
      if (evt_valid && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        chk("head_valid_held", int'(evt_valid), 1);
        chk("head_code_held", int'(evt_code), held_code);
        chk("head_press_held", int'(evt_press), held_press);
      end
      stalled    = evt_valid && !evt_ready;
      held_code  = int'(evt_code);
      held_press = int'(evt_press);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event code=%0d press=%0d req=none", evt_code, evt_press);
        end else begin
          e = exp_q.pop_front();
          chk("evt_code", int'(evt_code), e.code);
          chk("evt_press", int'(evt_press), int'(e.press));
        end
      end
    end
  end

  initial begin
    evt_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       evt_ready = 1'b1;
        2:       evt_ready = 1'b0;
        default: evt_ready = evt_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_keys[5];
    ovf_keys = '{9, 14, 3, 11, 0};
    aclr = 1'b1;
    phys = '0;
    ovf_clr = 1'b0;
    rdy_mode = 0;
    hold = 1'b0;
    model_occ = 0;
    exp_ovf = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_row_out", int'(row_out), 1);
    chk("rst_key", int'(key), 0);
    chk("rst_is_pressed", int'(is_pressed), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_code", int'(evt_code), 0);
    chk("rst_evt_press", int'(evt_press), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Key 6 held from reset: event after the third row-1 evaluation.
    phys[6] = 1'b1;
    aclr = 1'b0;
    repeat (4) run_scan();
    checks++;
    if (first_valid < 150 || first_valid > 152) begin
      failures++;
      $display("FAIL first_valid_cycle act=%0d req=151+-1", first_valid);
    end
    phys[6] = 1'b0;
    repeat (4) run_scan();

    // One-scan glitch must not produce an event.
    phys[6] = 1'b1;
    run_scan();
    phys[6] = 1'b0;
    repeat (3) run_scan();

    // Two keys together, then release the lower one.
    phys[5] = 1'b1;
    phys[6] = 1'b1;
    repeat (4) run_scan();
    phys[5] = 1'b0;
    repeat (4) run_scan();
    phys[6] = 1'b0;
    repeat (4) run_scan();

    // Stalled consumer, five presses into a four-entry FIFO.
    hold = 1'b1;
    model_occ = 0;
    exp_ovf = 1'b0;
    rdy_mode = 2;
    for (int k = 0; k < 5; k++) begin
      phys[ovf_keys[k]] = 1'b1;
      run_scan();
    end
    repeat (2) run_scan();
    chk("overflow_set", int'(overflow), int'(exp_ovf));
    run_scan(1'b1);
    hold = 1'b0;
    rdy_mode = 0;
    repeat (2) run_scan();
    phys = '0;
    repeat (4) run_scan();
    chk("overflow_after_drain", int'(overflow), 0);

    // Reset while key 6 is two samples into its debounce.
    phys[6] = 1'b1;
    repeat (2) run_scan();
    repeat (5) @(posedge clock);
    #1;
    aclr = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("midrst_row_out", int'(row_out), 1);
    chk("midrst_is_pressed", int'(is_pressed), 0);
    chk("midrst_evt_valid", int'(evt_valid), 0);
    chk("midrst_key", int'(key), 0);
    model_reset();
    @(posedge clock);
    #1;
    aclr = 1'b0;
    repeat (4) run_scan();
    phys[6] = 1'b0;
    repeat (4) run_scan();

    // Random key activity with a randomly stalling consumer.
    rdy_mode = 1;
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) phys[$urandom_range(0, NK-1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) phys[$urandom_range(0, NK-1)] ^= 1'b1;
      run_scan();
    end
    phys = '0;
    rdy_mode = 0;
    repeat (5) run_scan();
    chk("overflow_final", int'(overflow), 0);
    chk("missing_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
